// File: rtl/stats_collector_avlstrm_pkg.sv
// Shared definitions for the statistics collector.
// Holds the default widths, the register address map used by the stats
// channels, the {addr, val} beat layout and the collector FSM state type.
package stats_collector_avlstrm_pkg;

    localparam int DEF_NUM_CH     = 16;
    localparam int DEF_VAL_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    // Register addresses of the standard counters
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_RX_PKTS  = 8'h10;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_TX_PKTS  = 8'h14;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_RX_ERRS  = 8'h18;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_TX_ERRS  = 8'h1C;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_RX_BYTES = 8'h20;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_TX_BYTES = 8'h24;

    // One emitted beat: address in the MSBs, value in the LSBs
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_VAL_WIDTH-1:0]  val;
    } stats_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Width needed to hold an index 0..n-1 (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style streaming interface.
// Signals: valid, ready, data[WIDTH], sop, eop, empty[EMPTY_WIDTH].
// Modports: tx (source) and rx (sink).
interface avl_stream_if #(
    parameter int WIDTH       = 40,
    parameter int EMPTY_WIDTH = 1
);
    logic                   valid;
    logic                   ready;
    logic [WIDTH-1:0]       data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;

    modport tx (output valid, data, sop, eop, empty, input ready);
    modport rx (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/stats_collector_avlstrm_prio_enc.sv
// Lowest-set-bit priority encoder for the emit mask.
// Ports:
//   mask  - request vector
//   idx   - index of the lowest set bit (0 when none set)
//   found - any bit set
//   last  - the selected bit is the only set bit (no higher bits remain)
module stats_prio_enc
    import stats_collector_avlstrm_pkg::*;
#(
    parameter int N = DEF_NUM_CH
) (
    input  logic [N-1:0]              mask,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      found,
    output logic                      last
);
    localparam int IW = idx_width(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mask[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when nothing above it is set
    assign last = found && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/stats_collector_avlstrm.sv
// Statistics snapshot collector with an Avalon-ST output.
// On a trigger (snap_req or the periodic timer) all channel values are
// captured and emitted as one packet of {addr, val} beats, lowest channel
// first. With SKIP_UNCHANGED=1 only channels whose value differs from the
// last emitted value are sent. One trigger can be queued while sending;
// further ones are dropped and counted.
// Ports:
//   Clk, Rst     - clock, asynchronous active-high reset
//   stats_val    - live values, channel i at [i*VAL_WIDTH +: VAL_WIDTH]
//   stats_addr   - static register address per channel
//   snap_req     - single-cycle snapshot request
//   stats_out    - streaming output, data = {addr, val}
//   busy         - high while a snapshot is being processed
//   overrun_cnt  - saturating count of dropped triggers
module stats_collector_avlstrm
    import stats_collector_avlstrm_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int VAL_WIDTH      = DEF_VAL_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int PERIOD         = 1024,
    parameter int SKIP_UNCHANGED = 0
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH*VAL_WIDTH-1:0]  stats_val,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] stats_addr,
    input  logic                         snap_req,
    avl_stream_if.tx                     stats_out,
    output logic                         busy,
    output logic [15:0]                  overrun_cnt
);
    localparam int IW = idx_width(NUM_CH);

    state_t                        state, state_nxt;
    logic [NUM_CH*VAL_WIDTH-1:0]   snapshot;
    logic [NUM_CH*VAL_WIDTH-1:0]   last_sent;
    logic [NUM_CH-1:0]             mask;
    logic [NUM_CH-1:0]             emit_mask;
    logic                          pending;
    logic                          first;
    logic                          tick;
    logic                          trigger;
    logic                          start;
    logic                          accept;
    logic                          beat_valid;
    logic [IW-1:0]                 idx;
    logic                          found;
    logic                          last;
    logic [VAL_WIDTH-1:0]          cur_val;
    logic [ADDR_WIDTH-1:0]         cur_addr;

    // Free-running snapshot timer, independent of the FSM
    generate
        if (PERIOD > 0) begin : g_timer
            localparam int TW = idx_width(PERIOD);
            logic [TW-1:0] timer;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst)
                    timer <= '0;
                else if (timer == TW'(PERIOD - 1))
                    timer <= '0;
                else
                    timer <= timer + TW'(1);
            end

            assign tick = (timer == TW'(PERIOD - 1));
        end else begin : g_no_timer
            assign tick = 1'b0;
        end
    endgenerate

    assign trigger = snap_req | tick;
    assign start   = (state == ST_IDLE) && (trigger || pending);

    stats_prio_enc #(
        .N (NUM_CH)
    ) u_prio_enc (
        .mask  (mask),
        .idx   (idx),
        .found (found),
        .last  (last)
    );

    assign beat_valid = (state == ST_SEND) && found;
    assign accept     = beat_valid && stats_out.ready;

    always_comb begin
        emit_mask = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (SKIP_UNCHANGED == 0)
                emit_mask[i] = 1'b1;
            else
                emit_mask[i] = (stats_val[i*VAL_WIDTH +: VAL_WIDTH] !=
                                last_sent[i*VAL_WIDTH +: VAL_WIDTH]);
        end
    end

    always_comb begin
        cur_val  = '0;
        cur_addr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx == IW'(i)) begin
                cur_val  = snapshot[i*VAL_WIDTH +: VAL_WIDTH];
                cur_addr = stats_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // An empty emit mask still spends one cycle in SEND so busy is visible
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (trigger || pending) state_nxt = ST_SEND;
            ST_SEND: if (!found || (accept && last)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            snapshot    <= '0;
            last_sent   <= '0;
            mask        <= '0;
            first       <= 1'b0;
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (start) begin
                snapshot <= stats_val;
                mask     <= emit_mask;
                first    <= 1'b1;
            end else if (accept) begin
                first <= 1'b0;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (idx == IW'(i)) begin
                        mask[i]                                <= 1'b0;
                        last_sent[i*VAL_WIDTH +: VAL_WIDTH]    <= cur_val;
                    end
                end
            end

            // A trigger in IDLE is consumed by start; in SEND it queues or overruns
            if (start)
                pending <= 1'b0;
            else if ((state == ST_SEND) && trigger) begin
                if (!pending)
                    pending <= 1'b1;
                else if (overrun_cnt != 16'hFFFF)
                    overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

    assign busy            = (state != ST_IDLE);
    assign stats_out.valid = beat_valid;
    assign stats_out.sop   = beat_valid && first;
    assign stats_out.eop   = beat_valid && last;
    assign stats_out.data  = {cur_addr, cur_val};
    assign stats_out.empty = '0;

endmodule

// File: tb/tb_stats_collector_avlstrm.sv
// Directed testbench for stats_collector_avlstrm.
// dut0: SKIP=0, timer off; dut1: SKIP=1, timer off; dut2: SKIP=0, PERIOD=8.
module tb_stats_collector_avlstrm;
    import stats_collector_avlstrm_pkg::*;

    localparam int NCH = 4;
    localparam int VW  = 16;
    localparam int AW  = 8;
    localparam int DW  = AW + VW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rst2;
    logic              snap0, snap1, snap2;
    logic [NCH*VW-1:0] vals;
    logic [NCH*AW-1:0] addrs;
    logic              busy0, busy1, busy2;
    logic [15:0]       ovr0, ovr1, ovr2;
    logic [AW-1:0]     a_tab [4];

    int pass_cnt  = 0;
    int total_cnt = 0;

    avl_stream_if #(.WIDTH(DW)) s0 ();
    avl_stream_if #(.WIDTH(DW)) s1 ();
    avl_stream_if #(.WIDTH(DW)) s2 ();

    stats_collector_avlstrm #(
        .NUM_CH(NCH), .VAL_WIDTH(VW), .ADDR_WIDTH(AW), .PERIOD(0), .SKIP_UNCHANGED(0)
    ) dut0 (
        .Clk(clk), .Rst(rst), .stats_val(vals), .stats_addr(addrs), .snap_req(snap0),
        .stats_out(s0), .busy(busy0), .overrun_cnt(ovr0)
    );

    stats_collector_avlstrm #(
        .NUM_CH(NCH), .VAL_WIDTH(VW), .ADDR_WIDTH(AW), .PERIOD(0), .SKIP_UNCHANGED(1)
    ) dut1 (
        .Clk(clk), .Rst(rst), .stats_val(vals), .stats_addr(addrs), .snap_req(snap1),
        .stats_out(s1), .busy(busy1), .overrun_cnt(ovr1)
    );

    stats_collector_avlstrm #(
        .NUM_CH(NCH), .VAL_WIDTH(VW), .ADDR_WIDTH(AW), .PERIOD(8), .SKIP_UNCHANGED(0)
    ) dut2 (
        .Clk(clk), .Rst(rst2), .stats_val(vals), .stats_addr(addrs), .snap_req(snap2),
        .stats_out(s2), .busy(busy2), .overrun_cnt(ovr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input logic [VW-1:0] v0, v1, v2, v3);
        vals = {v3, v2, v1, v0};
    endtask

    task automatic test_reset();
        logic [19:0] got;
        rst = 1'b1; rst2 = 1'b1;
        snap0 = 1'b0; snap1 = 1'b0; snap2 = 1'b0;
        s0.ready = 1'b0; s1.ready = 1'b0; s2.ready = 1'b1;
        set_vals(16'd0, 16'd0, 16'd0, 16'd0);
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        got = {s0.valid, s0.sop, s0.eop, busy0, ovr0};
        total_cnt++;
        if (got !== 20'h0) $display("FAIL reset_dut0 got=%h exp=%h", got, 20'h0); else pass_cnt++;
        got = {s1.valid, s1.sop, s1.eop, busy1, ovr1};
        total_cnt++;
        if (got !== 20'h0) $display("FAIL reset_dut1 got=%h exp=%h", got, 20'h0); else pass_cnt++;
        got = {s2.valid, s2.sop, s2.eop, busy2, ovr2};
        total_cnt++;
        if (got !== 20'h0) $display("FAIL reset_dut2 got=%h exp=%h", got, 20'h0); else pass_cnt++;
        total_cnt++;
        if (s0.empty !== 1'b0) $display("FAIL reset_empty got=%b exp=0", s0.empty); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [VW-1:0]   ev [4];
        logic [DW+3:0]   got, exp;
        ev[0] = 16'd10; ev[1] = 16'd20; ev[2] = 16'd30; ev[3] = 16'd40;
        set_vals(ev[0], ev[1], ev[2], ev[3]);
        s0.ready = 1'b1;
        snap0 = 1'b1;
        tick();
        snap0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = {s0.valid, s0.sop, s0.eop, busy0, s0.data};
            exp = {1'b1, (k == 0), (k == 3), 1'b1, a_tab[k], ev[k]};
            total_cnt++;
            if (got !== exp) $display("FAIL basic_beat%0d got=%h exp=%h", k, got, exp);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({s0.valid, busy0} !== 2'b00)
            $display("FAIL basic_idle got=%b exp=00", {s0.valid, busy0});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] ev [4];
        logic [DW+2:0] got, exp;
        logic [DW-1:0] held;
        logic          stalled;
        int            k;
        ev[0] = 16'd5; ev[1] = 16'd6; ev[2] = 16'd7; ev[3] = 16'd8;
        set_vals(ev[0], ev[1], ev[2], ev[3]);
        s0.ready = 1'b1;
        snap0 = 1'b1;
        tick();
        snap0 = 1'b0;
        // Live values change after capture; beats must carry the frozen snapshot
        set_vals(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        k = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            s0.ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (stalled) begin
                total_cnt++;
                if ({s0.valid, s0.data} !== {1'b1, held})
                    $display("FAIL bp_hold got=%h exp=%h", {s0.valid, s0.data}, {1'b1, held});
                else pass_cnt++;
            end
            if (s0.valid === 1'b1) begin
                if (s0.ready) begin
                    got = {s0.sop, s0.eop, s0.valid, s0.data};
                    exp = {(k == 0), (k == 3), 1'b1, a_tab[k], ev[k]};
                    total_cnt++;
                    if (got !== exp) $display("FAIL bp_beat%0d got=%h exp=%h", k, got, exp);
                    else pass_cnt++;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = s0.data;
                end
            end
            tick();
        end
        total_cnt++;
        if (k !== 4) $display("FAIL bp_count got=%0d exp=4", k); else pass_cnt++;
        total_cnt++;
        if (s0.valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", s0.valid); else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [VW-1:0] ev [8];
        logic [DW+1:0] seen [8];
        logic [DW+1:0] exp;
        int            n;
        int            extra;
        ev[0] = 16'd1;  ev[1] = 16'd2;  ev[2] = 16'd3;  ev[3] = 16'd4;
        ev[4] = 16'd11; ev[5] = 16'd12; ev[6] = 16'd13; ev[7] = 16'd14;
        set_vals(ev[0], ev[1], ev[2], ev[3]);
        s0.ready = 1'b0;
        snap0 = 1'b1;
        tick();
        snap0 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            snap0 = 1'b1;
            tick();
            snap0 = 1'b0;
        end
        total_cnt++;
        if (ovr0 !== 16'd2) $display("FAIL ovr_count got=%0d exp=2", ovr0); else pass_cnt++;
        total_cnt++;
        if ({s0.valid, s0.sop, s0.data} !== {2'b11, a_tab[0], ev[0]})
            $display("FAIL ovr_stalled_beat got=%h exp=%h", {s0.valid, s0.sop, s0.data},
                     {2'b11, a_tab[0], ev[0]});
        else pass_cnt++;
        set_vals(ev[4], ev[5], ev[6], ev[7]);
        s0.ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 8; c++) begin
            if (s0.valid === 1'b1) begin
                seen[n] = {s0.sop, s0.eop, s0.data};
                n++;
            end
            tick();
        end
        total_cnt++;
        if (n !== 8) $display("FAIL ovr_beats got=%0d exp=8", n); else pass_cnt++;
        for (int i = 0; i < 8 && i < n; i++) begin
            exp = {((i % 4) == 0), ((i % 4) == 3), a_tab[i % 4], ev[i]};
            total_cnt++;
            if (seen[i] !== exp) $display("FAIL ovr_beat%0d got=%h exp=%h", i, seen[i], exp);
            else pass_cnt++;
        end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (s0.valid === 1'b1) extra++;
            tick();
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL ovr_no_third got=%0d exp=0", extra); else pass_cnt++;
        total_cnt++;
        if (ovr0 !== 16'd2) $display("FAIL ovr_final got=%0d exp=2", ovr0); else pass_cnt++;
    endtask

    task automatic test_skip();
        logic [VW-1:0] ev [4];
        logic [DW+3:0] got, exp;
        ev[0] = 16'd10; ev[1] = 16'd20; ev[2] = 16'd30; ev[3] = 16'd40;
        set_vals(ev[0], ev[1], ev[2], ev[3]);
        s1.ready = 1'b1;
        snap1 = 1'b1;
        tick();
        snap1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = {s1.valid, s1.sop, s1.eop, busy1, s1.data};
            exp = {1'b1, (k == 0), (k == 3), 1'b1, a_tab[k], ev[k]};
            total_cnt++;
            if (got !== exp) $display("FAIL skip_first%0d got=%h exp=%h", k, got, exp);
            else pass_cnt++;
            tick();
        end
        set_vals(16'd10, 16'd20, 16'd31, 16'd40);
        snap1 = 1'b1;
        tick();
        snap1 = 1'b0;
        got = {s1.valid, s1.sop, s1.eop, busy1, s1.data};
        exp = {4'b1111, a_tab[2], 16'd31};
        total_cnt++;
        if (got !== exp) $display("FAIL skip_changed got=%h exp=%h", got, exp); else pass_cnt++;
        tick();
        total_cnt++;
        if ({s1.valid, busy1} !== 2'b00)
            $display("FAIL skip_done got=%b exp=00", {s1.valid, busy1});
        else pass_cnt++;
    endtask

    task automatic test_no_change();
        snap1 = 1'b1;
        tick();
        snap1 = 1'b0;
        total_cnt++;
        if ({s1.valid, busy1} !== 2'b01)
            $display("FAIL nochg_busy got=%b exp=01", {s1.valid, busy1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({s1.valid, busy1} !== 2'b00)
            $display("FAIL nochg_idle got=%b exp=00", {s1.valid, busy1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({s1.valid, busy1} !== 2'b00)
            $display("FAIL nochg_quiet got=%b exp=00", {s1.valid, busy1});
        else pass_cnt++;
    endtask

    task automatic test_timer();
        int sop_q [$];
        int first_v;
        set_vals(16'd100, 16'd200, 16'd300, 16'd400);
        s2.ready = 1'b1;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        for (int n = 0; n < 34; n++) begin
            if (s2.sop === 1'b1) sop_q.push_back(n);
            tick();
        end
        total_cnt++;
        if (sop_q.size() !== 4) $display("FAIL timer_count got=%0d exp=4", sop_q.size());
        else pass_cnt++;
        for (int i = 0; i < sop_q.size() && i < 4; i++) begin
            total_cnt++;
            if (sop_q[i] !== 8 * (i + 1))
                $display("FAIL timer_sop%0d got=%0d exp=%0d", i, sop_q[i], 8 * (i + 1));
            else pass_cnt++;
        end
        // Third beat of the snapshot that started at cycle 32
        total_cnt++;
        if ({s2.valid, s2.data} !== {1'b1, a_tab[2], 16'd300})
            $display("FAIL timer_midsend got=%h exp=%h", {s2.valid, s2.data}, {1'b1, a_tab[2], 16'd300});
        else pass_cnt++;
        rst2 = 1'b1;
        #1;
        total_cnt++;
        if ({s2.valid, s2.sop, s2.eop, busy2} !== 4'b0000)
            $display("FAIL rst_midsend got=%b exp=0000", {s2.valid, s2.sop, s2.eop, busy2});
        else pass_cnt++;
        tick();
        rst2 = 1'b0;
        first_v = -1;
        for (int n = 0; n < 12; n++) begin
            if (s2.valid === 1'b1 && first_v < 0) first_v = n;
            tick();
        end
        total_cnt++;
        if (first_v !== 8) $display("FAIL rst_restart got=%0d exp=8", first_v); else pass_cnt++;
    endtask

    initial begin
        a_tab[0] = REG_RX_PKTS;
        a_tab[1] = REG_TX_PKTS;
        a_tab[2] = REG_RX_ERRS;
        a_tab[3] = REG_TX_ERRS;
        addrs = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_skip();
        test_no_change();
        test_timer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stats_collector_avlstrm.md
STATS_COLLECTOR_AVLSTRM -- requirements
Module: stats_collector_avlstrm

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of stats channels.
REQ-002 SHALL have parameter VAL_WIDTH, default 32, width of each stats value.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, width of each register address.
REQ-004 SHALL have parameter PERIOD, default 1024, auto-snapshot interval in cycles; 0 disables the timer.
REQ-005 SHALL have parameter SKIP_UNCHANGED, default 0; 1 emits only channels changed since their last emission.
REQ-006 SHALL have port Clk, input, 1, sole clock.
REQ-007 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port stats_val, input, NUM_CH*VAL_WIDTH, live values; channel i at bits [i*VAL_WIDTH +: VAL_WIDTH].
REQ-009 SHALL have port stats_addr, input, NUM_CH*ADDR_WIDTH, static register address per channel.
REQ-010 SHALL have port snap_req, input, 1, single-cycle snapshot request.
REQ-011 SHALL have port stats_out, avl_stream_if.tx, WIDTH = ADDR_WIDTH+VAL_WIDTH; uses valid, ready, data, sop and eop; empty is driven to 0.
REQ-012 SHALL have port busy, output, 1, high while not in IDLE.
REQ-013 SHALL have port overrun_cnt, output, 16, saturating count of dropped triggers.

Function
REQ-014 SHALL pack each beat's data as {addr, val}, with addr in the MSBs.
REQ-015 SHALL implement the timer as a counter 0..PERIOD-1 that pulses a trigger on wrap and runs continuously, independent of FSM state.
REQ-016 SHALL define trigger as snap_req OR the timer pulse; a simultaneous snap_req and timer pulse counts as one trigger.
REQ-017 SHALL implement FSM states IDLE and SEND.
REQ-018 SHALL, in IDLE when a trigger or pending is present, capture all NUM_CH values into the snapshot registers at that edge, compute the emit mask, clear pending, and enter SEND.
REQ-019 SHALL set every emit-mask bit when SKIP_UNCHANGED=0; otherwise bit i SHALL be set iff snapshot[i] differs from last_sent[i].
REQ-020 SHALL return to IDLE from the capture edge with no beats emitted when the emit mask is all zero.
REQ-021 SHALL, in SEND, present the lowest set mask bit as the current beat with valid=1.
REQ-022 SHALL assert sop on the first beat of a snapshot.
REQ-023 SHALL assert eop on the beat with no higher set mask bit; a single-beat snapshot SHALL carry both sop and eop.
REQ-024 SHALL hold data, sop and eop stable while valid=1 and ready=0.
REQ-025 SHALL, on an accepted beat (valid and ready), clear that mask bit, set last_sent[i] to snapshot[i], and advance to the next set bit in the following cycle with no bubble.
REQ-026 SHALL return to IDLE after the eop beat is accepted; a trigger in that same cycle SHALL set pending.
REQ-027 SHALL latency: trigger in cycle T while in IDLE samples stats_val at the end of T, with the first valid beat in T+1.
REQ-028 SHALL set pending on a trigger while in SEND when pending=0.
REQ-029 SHALL drop a trigger while in SEND when pending=1 and increment overrun_cnt, saturating at 16'hFFFF.
REQ-030 SHALL keep snapshot values frozen during SEND; changes on stats_val SHALL not affect in-flight beats.

Reset
REQ-031 SHALL, on Rst, asynchronously force state=IDLE, valid=0, sop=0, eop=0, busy=0, overrun_cnt=0, pending=0, timer=0, mask=0, last_sent=0 and snapshot=0.
REQ-032 SHALL abandon any in-flight snapshot when reset is asserted mid-SEND, with no beat emitted after deassertion until a new trigger.

Structure
REQ-033 SHALL place the stats_t typedef ({addr, val}), the REG_* address constants and the default widths in the shared struct package.
REQ-034 SHALL implement the lowest-set-bit and higher-bits-remain logic in a sub-module stats_prio_enc (parameter N, outputs idx, found, last).

Verification
REQ-035 SHALL verify: NUM_CH=4, SKIP=0, ready=1, snap_req at T with vals 10,20,30,40 -> four beats T+1..T+4, sop at T+1, eop at T+4, data {addr_i,val_i}.
REQ-036 SHALL verify: SKIP=1, two snaps where only ch2 changes 30->31 -> second snapshot is one beat {addr_2,31} with sop=eop=1.
REQ-037 SHALL verify: SKIP=1 with no changes -> zero beats and busy high for exactly one cycle.
REQ-038 SHALL verify: ready toggled 1,0,0,1 mid-snapshot -> data held stable, no beat lost or duplicated, order 0..3 preserved.
REQ-039 SHALL verify: three snap_req pulses during a stalled SEND -> one pending snapshot follows the eop and overrun_cnt=2.
REQ-040 SHALL verify: PERIOD=8, ready=1, NUM_CH=4 -> snapshots start every 8 cycles; Rst asserted mid-SEND -> valid=0 immediately and timer restarts from 0.
